// File: rtl/gpu_pixel_arbiter.sv
// Shares the single pixel-output path between line rasterizer (priority) and fill engine.
// Latency: 1 clk from accept to out_valid_o; full throughput of 1 pixel/clk.
// Backpressure: out_ready_i low holds the output register and drops both readies.
module gpu_pixel_arbiter #(
    parameter int WIDTH_BITS  = 10,
    parameter int HEIGHT_BITS = 9,
    parameter int LINE_BURST  = 4,
    parameter int CNT_BITS    = 16
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   clear_i,
    input  logic                   line_valid_i,
    input  logic [WIDTH_BITS-1:0]  line_x_i,
    input  logic [HEIGHT_BITS-1:0] line_y_i,
    output logic                   line_ready_o,
    input  logic                   fill_valid_i,
    input  logic [WIDTH_BITS-1:0]  fill_x_i,
    input  logic [HEIGHT_BITS-1:0] fill_y_i,
    output logic                   fill_ready_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [WIDTH_BITS-1:0]  x_o,
    output logic [HEIGHT_BITS-1:0] y_o,
    output logic                   src_o,
    output logic [CNT_BITS-1:0]    line_count_o,
    output logic [CNT_BITS-1:0]    fill_count_o,
    output logic                   busy_o
);

    typedef struct packed {
        logic [WIDTH_BITS-1:0]  x;
        logic [HEIGHT_BITS-1:0] y;
        logic                   src;
    } pix_t;

    localparam logic [3:0] BURST_LIM = 4'(LINE_BURST);

    pix_t       out_q;
    pix_t       in_pix;
    logic [3:0] burst_cnt;
    logic       load_en;
    logic       grant_line;
    logic       grant_fill;
    logic       line_xfer;
    logic       fill_xfer;

    // Readies are held low during reset so engines keep valid and re-present.
    assign load_en = n_rst & (~out_valid_o | out_ready_i);

    always_comb begin
        grant_fill = fill_valid_i & (~line_valid_i | (burst_cnt == BURST_LIM));
        grant_line = line_valid_i & ~grant_fill;
        in_pix     = grant_fill ? pix_t'{fill_x_i, fill_y_i, 1'b1}
                                : pix_t'{line_x_i, line_y_i, 1'b0};
    end

    assign line_ready_o = load_en & grant_line;
    assign fill_ready_o = load_en & grant_fill;
    assign line_xfer    = line_valid_i & line_ready_o;
    assign fill_xfer    = fill_valid_i & fill_ready_o;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            out_valid_o <= 1'b0;
            out_q       <= '0;
        end else if (load_en) begin
            out_valid_o <= line_xfer | fill_xfer;
            if (line_xfer | fill_xfer) out_q <= in_pix;
        end
    end

    // Burst counter only tracks line wins that actually kept fill waiting.
    always_ff @(posedge clk) begin
        if (!n_rst || clear_i) begin
            burst_cnt    <= '0;
            line_count_o <= '0;
            fill_count_o <= '0;
        end else begin
            if (line_xfer) burst_cnt <= fill_valid_i ? burst_cnt + 4'd1 : 4'd0;
            else if (fill_xfer) burst_cnt <= 4'd0;
            if (line_xfer && line_count_o != '1) line_count_o <= line_count_o + CNT_BITS'(1);
            if (fill_xfer && fill_count_o != '1) fill_count_o <= fill_count_o + CNT_BITS'(1);
        end
    end

    assign x_o    = out_q.x;
    assign y_o    = out_q.y;
    assign src_o  = out_q.src;
    assign busy_o = out_valid_o | line_valid_i | fill_valid_i;

endmodule

// File: tb/tb_gpu_pixel_arbiter.sv
// Directed bench for gpu_pixel_arbiter with a cycle-level reference model and literal checkpoints.
// Model tracks the output pixel, line-win streak and counts as plain integers.
// Stall cycles come from out_ready low; stimulus changes only 1 time unit after posedge.
module tb_gpu_pixel_arbiter;

    localparam int WB = 10;
    localparam int HB = 9;
    localparam int LB = 4;
    localparam int CB = 16;
    localparam int CNT_MAX = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          clear_i;
    logic          line_valid_i, fill_valid_i, out_ready_i;
    logic [WB-1:0] line_x_i, fill_x_i;
    logic [HB-1:0] line_y_i, fill_y_i;
    logic          line_ready_o, fill_ready_o, out_valid_o, src_o, busy_o;
    logic [WB-1:0] x_o;
    logic [HB-1:0] y_o;
    logic [CB-1:0] line_count_o, fill_count_o;

    gpu_pixel_arbiter #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .LINE_BURST(LB), .CNT_BITS(CB)) dut (
        .clk(clk), .n_rst(n_rst), .clear_i(clear_i),
        .line_valid_i(line_valid_i), .line_x_i(line_x_i), .line_y_i(line_y_i), .line_ready_o(line_ready_o),
        .fill_valid_i(fill_valid_i), .fill_x_i(fill_x_i), .fill_y_i(fill_y_i), .fill_ready_o(fill_ready_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .x_o(x_o), .y_o(y_o), .src_o(src_o),
        .line_count_o(line_count_o), .fill_count_o(fill_count_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: what the framebuffer side should see.
    bit m_vld = 0;
    int m_x = 0, m_y = 0, m_src = 0;
    int m_run = 0;
    int m_lcnt = 0, m_fcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit acc_ok, gl, gf, lv, fv;
        lv = line_valid_i;
        fv = fill_valid_i;
        acc_ok = n_rst && (!m_vld || out_ready_i);
        gl = 0;
        gf = 0;
        if (lv && fv) begin
            if (m_run == LB) gf = 1; else gl = 1;
        end else if (lv) gl = 1;
        else if (fv) gf = 1;

        check("line_ready", 32'(line_ready_o), 32'(acc_ok && gl));
        check("fill_ready", 32'(fill_ready_o), 32'(acc_ok && gf));
        check("out_valid",  32'(out_valid_o),  32'(m_vld));
        check("x",          32'(x_o),          32'(m_x));
        check("y",          32'(y_o),          32'(m_y));
        check("src",        32'(src_o),        32'(m_src));
        check("line_count", 32'(line_count_o), 32'(m_lcnt));
        check("fill_count", 32'(fill_count_o), 32'(m_fcnt));
        check("busy",       32'(busy_o),       32'(m_vld || lv || fv));

        if (!n_rst) begin
            m_vld = 0; m_x = 0; m_y = 0; m_src = 0;
            m_run = 0; m_lcnt = 0; m_fcnt = 0;
        end else begin
            if (acc_ok && gl) begin
                m_vld = 1; m_x = int'(line_x_i); m_y = int'(line_y_i); m_src = 0;
                m_run = fv ? m_run + 1 : 0;
                if (m_lcnt < CNT_MAX) m_lcnt++;
            end else if (acc_ok && gf) begin
                m_vld = 1; m_x = int'(fill_x_i); m_y = int'(fill_y_i); m_src = 1;
                m_run = 0;
                if (m_fcnt < CNT_MAX) m_fcnt++;
            end else if (acc_ok) begin
                m_vld = 0;
            end
            if (clear_i) begin
                m_run = 0; m_lcnt = 0; m_fcnt = 0;
            end
        end
    endtask

    // One clock: check/advance model at negedge, return 1 time unit after posedge.
    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    bit exp_src [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bit got_src [10];

    initial begin
        n_rst = 1'b0; clear_i = 1'b0; out_ready_i = 1'b1;
        line_valid_i = 1'b1; line_x_i = 10'd1; line_y_i = 9'd1;
        fill_valid_i = 1'b1; fill_x_i = 10'd2; fill_y_i = 9'd2;
        @(posedge clk);
        #1;

        // Reset held with both valids high
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid_o), 0);
        check("rst_line_ready", 32'(line_ready_o), 0);
        check("rst_fill_ready", 32'(fill_ready_o), 0);
        check("rst_x", 32'(x_o), 0);
        check("rst_y", 32'(y_o), 0);
        check("rst_line_count", 32'(line_count_o), 0);
        n_rst = 1'b1; fill_valid_i = 1'b0; line_x_i = 10'd3; line_y_i = 9'd4;
        tick();
        check("first_valid", 32'(out_valid_o), 1);
        check("first_x", 32'(x_o), 3);
        check("first_y", 32'(y_o), 4);
        check("first_src", 32'(src_o), 0);
        line_valid_i = 1'b0;
        tick();

        // Starvation guard: L,L,L,L,F repeating
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            line_valid_i = 1'b1; line_x_i = 10'(100 + i); line_y_i = 9'(i);
            fill_valid_i = 1'b1; fill_x_i = 10'(200 + i); fill_y_i = 9'(i);
            tick();
            got_src[i] = src_o;
        end
        for (int i = 0; i < 10; i++) check($sformatf("burst_src[%0d]", i), 32'(got_src[i]), 32'(exp_src[i]));
        check("burst_line_count", 32'(line_count_o), 8);
        check("burst_fill_count", 32'(fill_count_o), 2);
        line_valid_i = 1'b0; fill_valid_i = 1'b0;
        tick();

        // Backpressure on a corner pixel
        line_valid_i = 1'b1; line_x_i = 10'd639; line_y_i = 9'd479;
        tick();
        out_ready_i = 1'b0;
        line_x_i = 10'd10; line_y_i = 9'd20;
        fill_valid_i = 1'b1; fill_x_i = 10'd1; fill_y_i = 9'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_x", 32'(x_o), 639);
            check("stall_y", 32'(y_o), 479);
            check("stall_valid", 32'(out_valid_o), 1);
            check("stall_readies", 32'({line_ready_o, fill_ready_o}), 0);
        end
        out_ready_i = 1'b1;
        tick();
        check("refill_x", 32'(x_o), 10);
        check("refill_y", 32'(y_o), 20);
        check("refill_src", 32'(src_o), 0);
        line_valid_i = 1'b0; fill_valid_i = 1'b0;
        tick();

        // Fill only
        fill_valid_i = 1'b1; fill_x_i = 10'd5; fill_y_i = 9'd7;
        tick();
        check("fill0_xy", 32'({x_o, y_o}), 32'({10'd5, 9'd7}));
        check("fill0_src", 32'(src_o), 1);
        fill_x_i = 10'd6;
        tick();
        check("fill1_xy", 32'({x_o, y_o}), 32'({10'd6, 9'd7}));
        check("fill1_src", 32'(src_o), 1);
        fill_valid_i = 1'b0;
        tick();

        // Saturation and clear-wins
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        line_valid_i = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            line_x_i = 10'(i); line_y_i = 9'(i);
            tick();
        end
        check("sat_fffe", 32'(line_count_o), 32'h0000_FFFE);
        tick();
        tick();
        tick();
        check("sat_ffff", 32'(line_count_o), 32'h0000_FFFF);
        clear_i = 1'b1;
        tick();
        check("clear_wins", 32'(line_count_o), 0);
        check("clear_out_valid", 32'(out_valid_o), 1);
        clear_i = 1'b0;
        tick();
        check("count_after_clear", 32'(line_count_o), 1);
        line_valid_i = 1'b0;
        tick();

        // Reset mid-stream drops the held pixel
        line_valid_i = 1'b1; line_x_i = 10'd7; line_y_i = 9'd8;
        tick();
        out_ready_i = 1'b0; line_valid_i = 1'b0;
        tick();
        check("held_valid", 32'(out_valid_o), 1);
        n_rst = 1'b0;
        tick();
        check("midrst_valid", 32'(out_valid_o), 0);
        check("midrst_busy", 32'(busy_o), 0);
        fill_valid_i = 1'b1;
        #1;
        check("midrst_busy_fill", 32'(busy_o), 1);
        check("midrst_fill_ready", 32'(fill_ready_o), 0);
        tick();
        n_rst = 1'b1;
        tick();
        fill_valid_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
